// File: rtl/fetch_unit_if.sv
// Fetch-side bus: the PC redirect inputs from decode, the instruction-memory port
// and the IF/ID register outputs, all grouped so the fetch unit takes one port.
interface fetch_unit_if;
  logic        stall;
  logic [1:0]  npc_sel;
  logic [31:0] NPC_B;
  logic [31:0] NPC_J;
  logic [31:0] NPC_JR;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_valid;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        valid_D;

  modport master (
    input  stall, npc_sel, NPC_B, NPC_J, NPC_JR, im_rdata, im_valid,
    output im_addr, instr_D, PC_D, PC8_D, valid_D
  );

  modport slave (
    output stall, npc_sel, NPC_B, NPC_J, NPC_JR, im_rdata, im_valid,
    input  im_addr, instr_D, PC_D, PC8_D, valid_D
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with one architectural delay slot. A redirect seen while
// the memory has no word ready is parked in PEND until the delay slot arrives.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic {FETCH = 1'b0, PEND = 1'b1} state_t;

  state_t      state_q;
  logic [31:0] pc_f_q;
  logic [31:0] pend_pc_q;
  logic [31:0] instr_d_q;
  logic [31:0] pc_d_q;
  logic        valid_d_q;

  logic        advance;
  logic        redirect;
  logic [31:0] sel_tgt;
  logic [31:0] target_d;
  logic [31:0] seq_pc_d;

  assign advance  = bus.im_valid & ~bus.stall;
  assign redirect = (bus.npc_sel != 2'b00) & ~bus.stall & (state_q == FETCH);
  assign seq_pc_d = pc_f_q + 32'd4;
  assign target_d = sel_tgt & ~32'h0000_0003;

  always_comb begin
    sel_tgt = seq_pc_d;
    case (bus.npc_sel)
      2'b01:   sel_tgt = bus.NPC_B;
      2'b10:   sel_tgt = bus.NPC_J;
      2'b11:   sel_tgt = bus.NPC_JR;
      default: sel_tgt = seq_pc_d;
    endcase
  end

  // The delay slot is always delivered; only the PC update depends on the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_f_q    <= RESET_PC;
      pend_pc_q <= 32'd0;
      instr_d_q <= 32'd0;
      pc_d_q    <= 32'd0;
      valid_d_q <= 1'b0;
    end else begin
      if (advance) begin
        instr_d_q <= bus.im_rdata;
        pc_d_q    <= pc_f_q;
        valid_d_q <= 1'b1;
      end else if (!bus.stall) begin
        instr_d_q <= 32'd0;
        pc_d_q    <= 32'd0;
        valid_d_q <= 1'b0;
      end

      case (state_q)
        FETCH: begin
          if (advance) begin
            pc_f_q <= redirect ? target_d : seq_pc_d;
          end else if (redirect) begin
            pend_pc_q <= target_d;
            state_q   <= PEND;
          end
        end
        PEND: begin
          if (advance) begin
            pc_f_q  <= pend_pc_q;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.im_addr = pc_f_q;
  assign bus.instr_D = instr_d_q;
  assign bus.PC_D    = pc_d_q;
  assign bus.PC8_D   = pc_d_q + 32'd8;
  assign bus.valid_D = valid_d_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a redirect-queue reference model predicts the
// state after every edge, and a monitor compares it against the DUT.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef struct {
    logic [31:0] imAddr;
    logic [31:0] instr;
    logic [31:0] pcD;
    logic [31:0] pc8D;
    logic        valid;
  } expect_t;

  logic clk;
  logic reset;
  fetch_unit_if bus();

  int checks;
  int failures;

  expect_t     expQ[$];
  logic [31:0] redirQ[$];
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mPcD;
  logic        mValid;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.im_rdata = memWord(bus.im_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: a redirect is remembered until the next completed fetch (the delay
  // slot) and then replaces the sequential PC; only one may be outstanding.
  task automatic applyStimulus(input logic rst, input logic st, input logic [1:0] sel,
                               input logic [31:0] b, input logic [31:0] j, input logic [31:0] jr,
                               input logic v);
    expect_t e;
    logic [31:0] tgt;
    reset        = rst;
    bus.stall    = st;
    bus.npc_sel  = sel;
    bus.NPC_B    = b;
    bus.NPC_J    = j;
    bus.NPC_JR   = jr;
    bus.im_valid = v;
    if (rst) begin
      mPc = RESET_PC;
      redirQ.delete();
      mInstr = 0;
      mPcD = 0;
      mValid = 0;
    end else if (!st) begin
      if (redirQ.size() == 0 && sel != 2'b00) begin
        tgt = (sel == 2'b01) ? b : (sel == 2'b10) ? j : jr;
        redirQ.push_back({tgt[31:2], 2'b00});
      end
      if (v) begin
        mInstr = memWord(mPc);
        mPcD   = mPc;
        mValid = 1'b1;
        mPc    = (redirQ.size() != 0) ? redirQ.pop_front() : mPc + 32'd4;
      end else begin
        mInstr = 0;
        mPcD   = 0;
        mValid = 0;
      end
    end
    e.imAddr = mPc;
    e.instr  = mInstr;
    e.pcD    = mPcD;
    e.pc8D   = mPcD + 32'd8;
    e.valid  = mValid;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("im_addr", bus.im_addr, e.imAddr);
        checkOutput("instr_D", bus.instr_D, e.instr);
        checkOutput("PC_D", bus.PC_D, e.pcD);
        checkOutput("PC8_D", bus.PC8_D, e.pc8D);
        checkOutput("valid_D", {31'd0, bus.valid_D}, {31'd0, e.valid});
      end
    end
  end

  initial begin
    logic st;
    logic v;
    logic rst;
    logic [1:0] sel;
    checks   = 0;
    failures = 0;
    mPc = RESET_PC;
    mInstr = 0;
    mPcD = 0;
    mValid = 0;
    reset = 1'b1;
    bus.stall = 0;
    bus.npc_sel = 0;
    bus.NPC_B = 0;
    bus.NPC_J = 0;
    bus.NPC_JR = 0;
    bus.im_valid = 0;

    applyStimulus(1, 0, 2'b00, 0, 0, 0, 1);
    applyStimulus(1, 1, 2'b11, 0, 0, 0, 1);
    checkOutput("reset_im_addr", bus.im_addr, 32'h0000_3000);
    checkOutput("reset_PC8_D", bus.PC8_D, 32'h0000_0008);

    // Sequential fetch from reset
    repeat (3) applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);
    checkOutput("seq_im_addr", bus.im_addr, 32'h0000_300C);
    checkOutput("seq_PC_D", bus.PC_D, 32'h0000_3008);

    // Jump taken with the word ready: delay slot then target
    applyStimulus(0, 0, 2'b10, 0, 32'h0000_3100, 0, 1);
    checkOutput("jump_im_addr", bus.im_addr, 32'h0000_3100);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);

    // Branch while memory is not ready; toggling npc_sel while pending is ignored
    applyStimulus(0, 0, 2'b01, 32'h0000_3040, 0, 0, 0);
    applyStimulus(0, 0, 2'b11, 0, 0, 32'h0000_7777, 0);
    applyStimulus(0, 0, 2'b10, 0, 32'h0000_8888, 0, 1);
    checkOutput("pend_im_addr", bus.im_addr, 32'h0000_3040);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);

    // Stall with a jump-register pending on the inputs, then release
    repeat (3) applyStimulus(0, 1, 2'b11, 0, 0, 32'h0000_3013, 1);
    applyStimulus(0, 0, 2'b11, 0, 0, 32'h0000_3013, 1);
    checkOutput("jr_align_im_addr", bus.im_addr, 32'h0000_3010);

    // Wrap past the top of the address space
    applyStimulus(0, 0, 2'b10, 0, 32'hFFFF_FFFC, 0, 1);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);
    checkOutput("wrap_im_addr", bus.im_addr, 32'h0000_0000);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);

    // Reset while a redirect is pending and stall is high
    applyStimulus(0, 0, 2'b01, 32'h0000_5000, 0, 0, 0);
    applyStimulus(1, 1, 2'b10, 0, 32'h0000_6000, 0, 1);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 1);
    checkOutput("post_reset_im_addr", bus.im_addr, 32'h0000_3008);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 99) < 20);
      v   = ($urandom_range(0, 99) < 70);
      sel = ($urandom_range(0, 99) < 30) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(rst, st, sel, $urandom, $urandom, $urandom, v);
    end
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
      @(posedge clk);
      #3;
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port stall  input  1  hazard stall from the decode/hazard unit; holds F and D.
REQ-005 SHALL provide port npc_sel  input  2  next-PC select: 00 PC_F+4, 01 branch, 10 jump, 11 jump-register.
REQ-006 SHALL provide ports NPC_B, NPC_J, NPC_JR  input  32 each  branch, jump and jump-register targets computed in D.
REQ-007 SHALL provide port im_addr  output  32  instruction-memory address, equal to PC_F (combinational).
REQ-008 SHALL provide port im_rdata  input  32  instruction word returned for im_addr.
REQ-009 SHALL provide port im_valid  input  1  im_rdata is valid this cycle.
REQ-010 SHALL provide ports instr_D, PC_D, PC8_D  output  32 each  IF/ID register contents; PC8_D = PC_D+8.
REQ-011 SHALL provide port valid_D  output  1  instr_D holds a real instruction (0 = bubble).

Function
REQ-012 SHALL hold PC_F, a 2-state FSM (FETCH, PEND), pend_pc[31:0] and the IF/ID registers.
REQ-013 SHALL define advance = im_valid & ~stall; a fetch completes only on an advance cycle.
REQ-014 SHALL treat redirect = (npc_sel != 00) & ~stall, evaluated only in state FETCH; in PEND, npc_sel is ignored.
REQ-015 SHALL force target[1:0] to 2'b00 for every selected target (branch, J, JR).
REQ-016 SHALL compute PC_F+4 and PC_D+8 modulo 2^32 (0xFFFF_FFFC+4 = 0).
REQ-017 When stall=1, SHALL hold PC_F, state, pend_pc and all IF/ID outputs unchanged, whatever im_valid and npc_sel are.
REQ-018 FETCH, advance, no redirect: PC_F <= PC_F+4; instr_D <= im_rdata; PC_D <= PC_F; valid_D <= 1.
REQ-019 FETCH, advance, redirect: PC_F <= selected target; instr_D/PC_D load the fetched word (branch delay slot, never squashed); valid_D <= 1.
REQ-020 FETCH, ~stall, im_valid=0, no redirect: PC_F holds; IF/ID loads a bubble (instr_D=0, PC_D=0, valid_D=0).
REQ-021 FETCH, ~stall, im_valid=0, redirect: pend_pc <= selected target; state <= PEND; PC_F holds; IF/ID loads a bubble.
REQ-022 PEND, advance: IF/ID loads the fetched delay slot with valid_D=1; PC_F <= pend_pc; state <= FETCH.
REQ-023 PEND, ~stall, im_valid=0: PC_F and pend_pc hold; IF/ID loads a bubble; state stays PEND.
REQ-024 SHALL launch a new fetch at the updated PC_F in the cycle after any PC_F change; im_addr changes only at clock edges.
REQ-025 Redirect latency SHALL be exactly one fetch after the branch in D: the delay slot, then the target.

Reset
REQ-026 On reset=1 at a clock edge, SHALL set PC_F=RESET_PC, state=FETCH, pend_pc=0, instr_D=0, PC_D=0, valid_D=0.
REQ-027 Reset SHALL override stall, im_valid and npc_sel in the same cycle, including mid-PEND; any pending redirect is discarded.
REQ-028 After reset, PC8_D SHALL read 32'h0000_0008 (PC_D=0).
REQ-029 im_addr SHALL equal RESET_PC in the first cycle after reset deasserts.

Verification
REQ-030 Sequential: reset, im_valid=1 always, npc_sel=00 -> im_addr 0x3000, 0x3004, 0x3008; PC_D lags by one cycle; valid_D=1 from cycle 2.
REQ-031 Jump: D holds the j at 0x3004, npc_sel=10, NPC_J=0x3100, im_valid=1 -> delay slot 0x3008 enters D; next im_addr=0x3100.
REQ-032 Pending redirect: npc_sel=01, NPC_B=0x3040, im_valid=0 -> bubble in D, state PEND; im_valid=1 two cycles later -> delay slot enters D, then im_addr=0x3040; npc_sel toggling during PEND has no effect.
REQ-033 Stall: stall=1 for 3 cycles with im_valid=1, npc_sel=11 -> PC_F, instr_D, PC_D, valid_D frozen; jump-register applied only after stall drops.
REQ-034 JR alignment and wrap: NPC_JR=0x0000_3013 -> PC_F=0x3010; PC_F=0xFFFF_FFFC with sequential fetch -> next PC_F=0x0000_0000.
REQ-035 Reset in PEND with stall=1 -> PC_F=0x3000, state FETCH, valid_D=0; pend_pc target never fetched.
